regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the 32x32 single-cycle register file. It sits between decode (source/destination indices) and the ALU/writeback mux.
- Adds the following:
  - configurable width and depth;
  - hardwired-zero register 0;
  - optional write-to-read bypass;
  - a sequential clear engine that zeroes the array after reset, replacing file-based initialisation;
  - a ready flag;
  - a debug read port.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, 2..256. ADDR_W = $clog2(DEPTH) is a derived localparam.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read port; 0 = read returns the old value.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- regwrite  input  1  write enable.
- A1  input  ADDR_W  read address, port 1.
- A2  input  ADDR_W  read address, port 2.
- A3  input  ADDR_W  write address.
- W_Data  input  XLEN  write data.
- RD1  output  XLEN  read data, port 1.
- RD2  output  XLEN  read data, port 2.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  XLEN  debug read data; raw array contents, no bypass.
- ready  output  1  array initialised; writes accepted.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- State machine, two states: INIT and READY.
- Reset (rst=1 at a clock edge):
  - state <= INIT, clr_idx <= 0, ready <= 0.
  - Array contents are not touched by rst itself.
  - rst held high keeps the block in INIT with clr_idx=0.
- INIT, each cycle with rst=0:
  - mem[clr_idx] <= 0, clr_idx <= clr_idx+1.
  - When clr_idx == DEPTH-1: write 0, state <= READY, ready <= 1.
- Clear timing: ready rises exactly DEPTH clock edges after the first edge with rst=0. For DEPTH=32, ready is high after edge 32.
- Behaviour while in INIT:
  - regwrite is ignored; writes are dropped, not queued.
  - RD1, RD2 and dbg_data are forced to 0.
- Reset mid-INIT or in READY: returns to INIT and restarts the clear from clr_idx=0.
- READY, write path:
  - On a rising edge with regwrite=1, mem[A3] <= W_Data.
  - If ZERO_REG=1 and A3==0, the write is suppressed.
  - The FSM stays in READY until the next rst.
- READY, read path: combinational, zero-cycle latency. Priority for RDn (n=1,2):
  1. ZERO_REG=1 and An==0 -> 0.
  2. BYPASS=1 and regwrite=1 and A3==An and the write is not suppressed -> W_Data.
  3. Otherwise -> mem[An].
- Simultaneous events:
  - A1==A2 is allowed; both ports return the same value.
  - A write and a read to the same address in one cycle follow the BYPASS rule above.
  - A write and a debug read to the same address: dbg_data returns the old value.
- dbg_data = mem[dbg_addr] in READY. Register 0 reads 0 when ZERO_REG=1, which holds because writes to it are suppressed and it is cleared in INIT.
- Reset values:
  - ready=0.
  - RD1=RD2=dbg_data=0, since outputs are forced to 0 in INIT.
- Address width: addresses are exactly ADDR_W bits, so there is no out-of-range case.
- clr_idx is ADDR_W+1 bits wide, or stops at DEPTH-1; it must not wrap into a second pass.
- Only READY accepts writes; the array never has two writers in one cycle.

Test Plan:
- Reset/clear: pulse rst for 2 cycles, then release.
  - Required: ready=0 for exactly 32 edges, then 1.
  - After ready, all 32 dbg_data reads = 0.
- Writes ignored in INIT: during INIT drive regwrite=1, A3=5, W_Data=0xDEADBEEF.
  - Required: after ready, dbg_addr=5 gives 0. RD1 stays 0 during INIT.
- Write then read: in READY write 0x12345678 to register 7.
  - Required: next cycle A1=7 -> RD1=0x12345678.
  - With A2=7 also, RD2=0x12345678.
- Bypass:
  - BYPASS=1, regwrite=1, A3=A1=9, W_Data=0xA5A5A5A5, register 9 previously 0x11: RD1=0xA5A5A5A5 in the same cycle; dbg_data(9)=0x11 in that cycle.
  - BYPASS=0: RD1=0x11 in that cycle, then 0xA5A5A5A5 after the edge.
- Zero register: write 0xFFFFFFFF to register 0 with ZERO_REG=1.
  - Required: RD1, RD2 and dbg_data for address 0 all read 0, including the bypass cycle.
  - With ZERO_REG=0: reads 0xFFFFFFFF after the edge.
- Reset mid-operation:
  - Fill registers 1..31 with their index value, then assert rst at the 10th INIT cycle of a second reset.
  - Required: clear restarts, ready rises 32 edges after release, and all registers read 0.
  - Repeat at DEPTH=8, XLEN=16: ready after 8 edges.

Source files
------------

// File: rtl/regfile_param_if.sv
// Register-file access bundle: two read ports, one write port, a debug read port and the ready flag.
// The master side belongs to decode/writeback, the slave side to the register file.
interface regfile_param_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              regwrite;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic [XLEN-1:0]   W_Data;
    logic [XLEN-1:0]   RD1;
    logic [XLEN-1:0]   RD2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_data;
    logic              ready;

    modport master (
        output regwrite, A1, A2, A3, W_Data, dbg_addr,
        input  RD1, RD2, dbg_data, ready
    );

    modport slave (
        input  regwrite, A1, A2, A3, W_Data, dbg_addr,
        output RD1, RD2, dbg_data, ready
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with optional zero register and write bypass; combinational reads, writes at the edge.
// After reset a sequential engine clears one entry per cycle; ready rises DEPTH edges later and gates writes.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic             clk,
    input logic             rst,
    regfile_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t            state;
    logic [ADDR_W:0]   clr_idx;
    logic              ready_q;
    logic [XLEN-1:0]   mem [DEPTH];
    logic              wr_en;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   dbg;

    // A write to register 0 is dropped entirely when it is hardwired, so it never bypasses either.
    assign wr_en = (state == READY) && bus.regwrite &&
                   !((ZERO_REG != 0) && (bus.A3 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    mem[clr_idx[ADDR_W-1:0]] <= '0;
                    if (clr_idx == LAST_IDX) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                READY: begin
                    if (wr_en) begin
                        mem[bus.A3] <= bus.W_Data;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_comb begin
        rd1 = '0;
        if (state == READY) begin
            if ((ZERO_REG != 0) && (bus.A1 == '0)) begin
                rd1 = '0;
            end else if ((BYPASS != 0) && wr_en && (bus.A3 == bus.A1)) begin
                rd1 = bus.W_Data;
            end else begin
                rd1 = mem[bus.A1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (state == READY) begin
            if ((ZERO_REG != 0) && (bus.A2 == '0)) begin
                rd2 = '0;
            end else if ((BYPASS != 0) && wr_en && (bus.A3 == bus.A2)) begin
                rd2 = bus.W_Data;
            end else begin
                rd2 = mem[bus.A2];
            end
        end
    end

    // Debug port shows raw storage: no forwarding of the in-flight write.
    always_comb begin
        dbg = '0;
        if (state == READY) begin
            dbg = mem[bus.dbg_addr];
        end
    end

    assign bus.RD1      = rd1;
    assign bus.RD2      = rd2;
    assign bus.dbg_data = dbg;
    assign bus.ready    = ready_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (default, no-bypass/ordinary-r0, 8x16) checked through a scoreboard queue.
module tb_regfile_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic        regwrite, regwrite2;
    logic [4:0]  a1, a2, a3, dbg;
    logic [31:0] wd;
    logic [2:0]  b1, b2, b3, bdbg;
    logic [15:0] wd2;

    regfile_param_if #(.XLEN(32), .DEPTH(32)) if0 ();
    regfile_param_if #(.XLEN(32), .DEPTH(32)) if1 ();
    regfile_param_if #(.XLEN(16), .DEPTH(8))  if2 ();

    assign if0.regwrite = regwrite;
    assign if0.A1 = a1;
    assign if0.A2 = a2;
    assign if0.A3 = a3;
    assign if0.W_Data = wd;
    assign if0.dbg_addr = dbg;
    assign if1.regwrite = regwrite;
    assign if1.A1 = a1;
    assign if1.A2 = a2;
    assign if1.A3 = a3;
    assign if1.W_Data = wd;
    assign if1.dbg_addr = dbg;
    assign if2.regwrite = regwrite2;
    assign if2.A1 = b1;
    assign if2.A2 = b2;
    assign if2.A3 = b3;
    assign if2.W_Data = wd2;
    assign if2.dbg_addr = bdbg;

    regfile_param #(.XLEN(32), .DEPTH(32), .BYPASS(1), .ZERO_REG(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    regfile_param #(.XLEN(32), .DEPTH(32), .BYPASS(0), .ZERO_REG(0))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    regfile_param #(.XLEN(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(1))
        dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [4:0]  ra1, ra2, wa, da;
        logic [31:0] wdat;
        logic [31:0] e_rd1, e_rd2, e_dbg;
        logic [31:0] e1_rd1, e1_dbg;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return if0.RD1;
            1:       return if0.RD2;
            2:       return if0.dbg_data;
            3:       return {31'd0, if0.ready};
            4:       return if1.RD1;
            5:       return if1.dbg_data;
            6:       return {31'd0, if1.ready};
            7:       return {16'd0, if2.RD1};
            8:       return {16'd0, if2.dbg_data};
            9:       return {31'd0, if2.ready};
            default: return {16'd0, if2.RD2};
        endcase
    endfunction

    task automatic expect_v(input string n, input int sel, input logic [31:0] e);
        exp_t r;
        r.name = n;
        r.sel  = sel;
        r.exp  = e;
        sbq.push_back(r);
    endtask

    // Outputs are sampled on the falling edge, half a period after inputs settle.
    task automatic compare_all();
        exp_t r;
        logic [31:0] got;
        @(negedge clk);
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            got = observe(r.sel);
            n_cmp++;
            if (got !== r.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", r.name, got, r.exp, $time);
            end
        end
    endtask

    task automatic count_ready(input int n, input int sel_a, input int sel_b, input int rd_sel);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            expect_v("ready_edge", sel_a, (k >= n) ? 32'd1 : 32'd0);
            if (sel_b >= 0) expect_v("ready_edge_b", sel_b, (k >= n) ? 32'd1 : 32'd0);
            if (k < n) expect_v("rd_forced_zero_init", rd_sel, 32'd0);
            compare_all();
        end
    endtask

    task automatic scan_zero32();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            regwrite = 1'b0;
            dbg = 5'(i);
            a1  = 5'(i);
            expect_v("clear_dbg0", 2, 32'd0);
            expect_v("clear_dbg1", 5, 32'd0);
            expect_v("clear_rd1_0", 0, 32'd0);
            expect_v("clear_rd1_1", 4, 32'd0);
            compare_all();
        end
    endtask

    task automatic scan_zero8();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            regwrite2 = 1'b0;
            bdbg = 3'(i);
            b1   = 3'(i);
            b2   = 3'(i);
            expect_v("clear8_dbg", 8, 32'd0);
            expect_v("clear8_rd1", 7, 32'd0);
            expect_v("clear8_rd2", 10, 32'd0);
            compare_all();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd7,  5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd7,  5'd7,  5'd0,  5'd7,  32'h0,        32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b1, 5'd9,  5'd7,  5'd9,  5'd9,  32'h00000011, 32'h00000011, 32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd9,  5'd9,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000011, 32'h00000011, 32'h00000011};
        vecs[4] = '{1'b0, 5'd9,  5'd0,  5'd0,  5'd9,  32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5] = '{1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7] = '{1'b1, 5'd31, 5'd30, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[8] = '{1'b0, 5'd31, 5'd31, 5'd0,  5'd31, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};

        rst = 1'b1; rst2 = 1'b1;
        regwrite = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd = '0; dbg = '0;
        regwrite2 = 1'b0; b1 = '0; b2 = '0; b3 = '0; wd2 = '0; bdbg = '0;

        // Two reset cycles, then reset-state checks.
        repeat (2) @(posedge clk);
        #1;
        expect_v("rst_ready0", 3, 32'd0);
        expect_v("rst_ready1", 6, 32'd0);
        expect_v("rst_rd1", 0, 32'd0);
        expect_v("rst_rd2", 1, 32'd0);
        expect_v("rst_dbg", 2, 32'd0);
        compare_all();

        // Release with a write pending on r5 throughout INIT; it must be dropped.
        rst = 1'b0;
        regwrite = 1'b1; a3 = 5'd5; wd = 32'hDEADBEEF; a1 = 5'd5; a2 = 5'd5;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 32) regwrite = 1'b0;
            expect_v("init_ready0", 3, (k >= 32) ? 32'd1 : 32'd0);
            expect_v("init_ready1", 6, (k >= 32) ? 32'd1 : 32'd0);
            expect_v("init_rd1", 0, 32'd0);
            compare_all();
        end
        @(posedge clk);
        #1;
        dbg = 5'd5;
        expect_v("init_write_dropped", 2, 32'd0);
        expect_v("init_write_dropped1", 5, 32'd0);
        compare_all();
        scan_zero32();

        for (int v = 0; v < 9; v++) begin
            @(posedge clk);
            #1;
            regwrite = vecs[v].we;
            a1 = vecs[v].ra1; a2 = vecs[v].ra2; a3 = vecs[v].wa;
            dbg = vecs[v].da; wd = vecs[v].wdat;
            expect_v($sformatf("vec%0d_rd1", v), 0, vecs[v].e_rd1);
            expect_v($sformatf("vec%0d_rd2", v), 1, vecs[v].e_rd2);
            expect_v($sformatf("vec%0d_dbg", v), 2, vecs[v].e_dbg);
            expect_v($sformatf("vec%0d_nobyp_rd1", v), 4, vecs[v].e1_rd1);
            expect_v($sformatf("vec%0d_nobyp_dbg", v), 5, vecs[v].e1_dbg);
            compare_all();
        end

        // Fill 1..31 with their index, then reset and interrupt the clear at its 10th cycle.
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            regwrite = 1'b1; a3 = 5'(i); wd = 32'(i);
        end
        @(posedge clk);
        #1;
        regwrite = 1'b0; dbg = 5'd17; a1 = 5'd31;
        expect_v("fill_dbg17", 2, 32'd17);
        expect_v("fill_dbg17_1", 5, 32'd17);
        expect_v("fill_rd1_31", 0, 32'd31);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; a1 = 5'd17;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        expect_v("midinit_ready", 3, 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_ready(32, 3, 6, 0);
        scan_zero32();

        // Small configuration: first clear, fill, then the interrupted clear.
        rst2 = 1'b0;
        count_ready(8, 9, -1, 7);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            regwrite2 = 1'b1; b3 = 3'(i); wd2 = 16'h0100 + 16'(i);
        end
        @(posedge clk);
        #1;
        regwrite2 = 1'b0; bdbg = 3'd3; b1 = 3'd7;
        expect_v("d8_fill_dbg3", 8, 32'h0103);
        expect_v("d8_fill_rd1_7", 7, 32'h0107);
        compare_all();
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        count_ready(8, 9, -1, 7);
        scan_zero8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
